// File: rtl/truth_table_checker_if.sv
// Bundle between a truth_table_checker and the lab harness driving its
// configuration port and the DUT under test.
interface truth_table_checker_if #(
    parameter int N_IN = 4
);
    logic            cfg_we;
    logic [N_IN-1:0] cfg_addr;
    logic            cfg_exp;
    logic            cfg_care;
    logic            start;
    logic            dut_out;
    logic [N_IN-1:0] vec_out;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic [N_IN:0]   tested_count;
    logic [N_IN-1:0] first_err_vec;
    logic            first_err_valid;

    modport master (
        output cfg_we, cfg_addr, cfg_exp, cfg_care, start, dut_out,
        input  vec_out, busy, done, pass, err_count, tested_count,
               first_err_vec, first_err_valid
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_exp, cfg_care, start, dut_out,
        output vec_out, busy, done, pass, err_count, tested_count,
               first_err_vec, first_err_valid
    );
endinterface

// File: rtl/truth_table_checker.sv
// Sweeps every care vector of a 2^N_IN-entry truth table onto a DUT, holds each
// for HOLD_CYCLES, and counts mismatches against the programmed expected bit.
module truth_table_checker #(
    parameter int N_IN        = 4,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    truth_table_checker_if.slave  bus
);
    localparam int DEPTH = 1 << N_IN;
    localparam int CNT_W = N_IN + 1;
    localparam int HC_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [N_IN-1:0]  IDX_ONE  = N_IN'(1);
    localparam logic [N_IN-1:0]  IDX_LAST = N_IN'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [HC_W-1:0]  HC_ONE   = HC_W'(1);
    localparam logic [HC_W-1:0]  HC_LAST  = HC_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, APPLY, DONE} state_t;

    state_t            state_q;
    logic [N_IN-1:0]   idx_q;
    logic [HC_W-1:0]   hold_q;
    logic [DEPTH-1:0]  care_q;
    logic [DEPTH-1:0]  exp_q;
    logic [N_IN-1:0]   vec_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic [CNT_W-1:0]  err_q;
    logic [CNT_W-1:0]  tested_q;
    logic [N_IN-1:0]   fev_q;
    logic              fevalid_q;

    logic last_idx_d;
    logic last_hold_d;
    logic mismatch_d;

    assign last_idx_d  = (idx_q == IDX_LAST);
    assign last_hold_d = (hold_q == HC_LAST);
    assign mismatch_d  = (bus.dut_out != exp_q[idx_q]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            hold_q    <= '0;
            care_q    <= '0;
            exp_q     <= '0;
            vec_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= '0;
            tested_q  <= '0;
            fev_q     <= '0;
            fevalid_q <= 1'b0;
        end else begin
            // Table is frozen during a sweep; a write alongside start lands first.
            if (bus.cfg_we && !busy_q) begin
                care_q[bus.cfg_addr] <= bus.cfg_care;
                exp_q[bus.cfg_addr]  <= bus.cfg_exp;
            end

            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_q   <= SCAN;
                        idx_q     <= '0;
                        err_q     <= '0;
                        tested_q  <= '0;
                        fev_q     <= '0;
                        fevalid_q <= 1'b0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        pass_q    <= 1'b0;
                    end
                end

                SCAN: begin
                    if (care_q[idx_q]) begin
                        vec_q   <= idx_q;
                        hold_q  <= '0;
                        state_q <= APPLY;
                    end else if (last_idx_d) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_q == '0);
                    end else begin
                        idx_q <= idx_q + IDX_ONE;
                    end
                end

                APPLY: begin
                    if (!last_hold_d) begin
                        hold_q <= hold_q + HC_ONE;
                    end else begin
                        tested_q <= tested_q + CNT_ONE;
                        if (mismatch_d) begin
                            err_q <= err_q + CNT_ONE;
                            if (!fevalid_q) begin
                                fev_q     <= idx_q;
                                fevalid_q <= 1'b1;
                            end
                        end
                        if (last_idx_d) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_q == '0) && !mismatch_d;
                        end else begin
                            idx_q   <= idx_q + IDX_ONE;
                            state_q <= SCAN;
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.vec_out         = vec_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.pass            = pass_q;
    assign bus.err_count       = err_q;
    assign bus.tested_count    = tested_q;
    assign bus.first_err_vec   = fev_q;
    assign bus.first_err_valid = fevalid_q;
endmodule
